fpga_cfg_loader: RTL and testbench
==================================

// Module: fpga_cfg_loader
// PURPOSE
//  Streaming configuration loader for the fpga fabric top.
//  - Accepts a framed 32-bit bitstream over a valid/ready interface.
//  - Drives prog_i together with a one-hot prog_shft into NCH independent
//    configuration shift chains.
//  - Verifies a per-frame XOR checksum.
//  - Asserts fab_en (the fabric data_en) only after a committed, error-free
//    load of every chain.
//  - Replaces hand-sequenced prog_shft/prog_i stimulus at fabric level.
// PARAMETERS
//  W    32  config word width; equals the fabric prog_i width
//  NCH  7   number of configuration chains; equals the fabric prog_shft width
// PORTS
//  clk           in   1      fabric clock; all logic on rising edge
//  nres          in   1      asynchronous, active-low reset
//  s_valid       in   1      bitstream word valid
//  s_data        in   W      bitstream word
//  s_ready       out  1      loader accepts word (transfer = s_valid & s_ready)
//  prog_i        out  W      config word to the fabric chains
//  prog_shft     out  NCH    one-hot shift enable; all-zero = hold
//  chain_loaded  out  NCH    bit i = chain i holds a checksum-verified frame
//  cfg_done      out  1      commit accepted; sticky until reset
//  cfg_err       out  1      protocol or checksum error; sticky until reset
//  fab_en        out  1      fabric data enable; equals cfg_done
// BEHAVIOUR
//  Reset (async assert, sync deassert)
//  - All outputs are 0 except s_ready. s_ready is 1 one cycle after nres rises.
//  - State is IDLE; chain_loaded is cleared.
//  - nres low mid-frame aborts the frame and forgets every chain.
//  Frame format
//  - HDR word: [W-1:24]=8'hA5 sync, [15:8]=chain idx, [7:0]=count N.
//  - Then N payload words, then one trailer = XOR of the N payload words.
//  - A HDR with idx 8'hFF and N ignored is a COMMIT.
//  States
//  - IDLE: s_ready=1. On HDR transfer:
//    - bad sync -> ERR
//    - idx=FF -> (chain_loaded all-ones ? DONE : ERR)
//    - idx>=NCH, or N=0 -> ERR
//    - else latch idx and N, clear chain_loaded[idx], clear acc -> SHIFT
//  - SHIFT: s_ready=1. Each transfer:
//    - next cycle prog_i=s_data and prog_shft=1<<idx (1-cycle latency)
//    - acc^=s_data, cnt++; after the Nth word -> CHECK
//    - a cycle with no transfer gives prog_shft=0 next cycle (stall-safe);
//      prog_i holds its last value
//  - CHECK: s_ready=1. Trailer transfer:
//    - trailer==acc -> set chain_loaded[idx], go IDLE
//    - otherwise -> ERR
//  - DONE: s_ready=0, cfg_done=1, fab_en=1, prog_shft=0. Terminal until reset.
//  - ERR: s_ready=0, cfg_err=1, fab_en=0, prog_shft=0. Terminal until reset.
//  Rules
//  - Reloading an already-loaded chain is legal; its bit reads 0 until the
//    new trailer verifies.
//  - prog_shft is never multi-hot. It is nonzero only on the cycle after a
//    SHIFT-state payload transfer.
//  - cnt is 8 bits; N=255 is legal with no wrap.
//  - s_valid asserted in DONE or ERR is ignored.
//  - cfg_done and cfg_err are never both set.
// STRUCTURE
//  - cfg_pkg holds:
//    - localparam SYNC=8'hA5 and CMD_COMMIT=8'hFF
//    - header field bit positions
//    - typedef enum {IDLE,SHIFT,CHECK,DONE,ERR} cfg_state_t
//  - No sub-module: a single FSM with counter, accumulator and output
//    registers.
// TESTING (W=32, NCH=7)
//  1. Reset, then HDR A5_00_00_02 + 0xF0000000, 0x0F000000 + trailer
//     0xFF000000 -> prog_shft=7'h01 for exactly 2 cycles carrying those
//     words; chain_loaded=7'h01.
//  2. Load chains 0..6, 8 words each, mirroring the nibble-walk pattern
//     F0000000..0000000F (trailer FFFFFFFF), then COMMIT A5_00_FF_00
//     -> cfg_done=1, fab_en=1, s_ready=0.
//  3. Same as 1 with trailer 0xFF000001 -> cfg_err=1, chain_loaded[0]=0,
//     fab_en stays 0; a later HDR is ignored.
//  4. s_valid toggled 1/0 through an 8-word payload -> prog_shft pulses only
//     after accepted words; word order and count are preserved.
//  5. Illegal headers each from reset:
//     - sync 0x5A -> cfg_err
//     - idx 7 -> cfg_err
//     - N=0 -> cfg_err
//     - COMMIT with chain_loaded=7'h3F -> cfg_err
//  6. nres pulsed low mid-payload (after word 3 of 8) -> all outputs zero
//     asynchronously; a fresh frame then loads normally.

Source files
------------

// File: rtl/cfg_pkg.sv
// cfg_pkg: header field layout, command codes and state type for fpga_cfg_loader
package cfg_pkg;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam logic [7:0] CMD_COMMIT = 8'hFF;
  localparam int SYNC_LSB = 24;
  localparam int IDX_LSB = 8;
  localparam int CNT_LSB = 0;
  typedef enum logic [2:0] {IDLE, SHIFT, CHECK, DONE, ERR} cfg_state_t;
endpackage

// File: rtl/fpga_cfg_loader.sv
// fpga_cfg_loader: framed valid/ready bitstream loader driving prog_i/prog_shft chains with XOR-checked frames and commit
module fpga_cfg_loader
  import cfg_pkg::*;
#(
  parameter int W = 32,
  parameter int NCH = 7
) (
  input  logic           clk,
  input  logic           nres,
  input  logic           s_valid,
  input  logic [W-1:0]   s_data,
  output logic           s_ready,
  output logic [W-1:0]   prog_i,
  output logic [NCH-1:0] prog_shft,
  output logic [NCH-1:0] chain_loaded,
  output logic           cfg_done,
  output logic           cfg_err,
  output logic           fab_en
);
  localparam int CW = NCH > 1 ? $clog2(NCH) : 1;
  cfg_state_t state;
  logic [CW-1:0] ci;
  logic [7:0] n, cnt, h_sync, h_idx, h_n;
  logic [W-1:0] acc;
  logic xfer, is_commit, is_load;
  assign h_sync = s_data[SYNC_LSB +: 8];
  assign h_idx = s_data[IDX_LSB +: 8];
  assign h_n = s_data[CNT_LSB +: 8];
  assign xfer = s_valid & s_ready;
  assign is_commit = h_sync == SYNC && h_idx == CMD_COMMIT;
  assign is_load = h_sync == SYNC && int'(h_idx) < NCH && h_n != 8'd0;
  assign fab_en = cfg_done;
  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      state <= IDLE;
      s_ready <= 1'b0;
      prog_i <= '0;
      prog_shft <= '0;
      chain_loaded <= '0;
      cfg_done <= 1'b0;
      cfg_err <= 1'b0;
      ci <= '0;
      n <= '0;
      cnt <= '0;
      acc <= '0;
    end else begin
      prog_shft <= '0;
      s_ready <= state == IDLE || state == SHIFT || state == CHECK;
      case (state)
        IDLE: if (xfer) begin
          if (is_commit && &chain_loaded) begin
            state <= DONE;
            cfg_done <= 1'b1;
            s_ready <= 1'b0;
          end else if (is_load) begin
            state <= SHIFT;
            ci <= h_idx[CW-1:0];
            n <= h_n;
            cnt <= '0;
            acc <= '0;
            chain_loaded[h_idx[CW-1:0]] <= 1'b0;
          end else begin
            state <= ERR;
            cfg_err <= 1'b1;
            s_ready <= 1'b0;
          end
        end
        SHIFT: if (xfer) begin
          prog_i <= s_data;
          prog_shft <= NCH'(1) << ci;
          acc <= acc ^ s_data;
          cnt <= cnt + 8'd1;
          if (cnt == n - 8'd1) state <= CHECK;
        end
        CHECK: if (xfer) begin
          if (s_data == acc) begin
            state <= IDLE;
            chain_loaded[ci] <= 1'b1;
          end else begin
            state <= ERR;
            cfg_err <= 1'b1;
            s_ready <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fpga_cfg_loader.sv
// tb_fpga_cfg_loader: directed scoreboard bench for fpga_cfg_loader
module tb_fpga_cfg_loader;
  logic clk = 0, nres = 1, s_valid = 0, s_ready;
  logic [31:0] s_data = 0, prog_i;
  logic [6:0] prog_shft, chain_loaded;
  logic cfg_done, cfg_err, fab_en;
  int errors = 0, checks = 0, pulses = 0, p0;
  logic [38:0] q[$];
  logic [38:0] e;
  fpga_cfg_loader #(.W(32), .NCH(7)) dut (
    .clk(clk), .nres(nres), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .prog_i(prog_i), .prog_shft(prog_shft), .chain_loaded(chain_loaded),
    .cfg_done(cfg_done), .cfg_err(cfg_err), .fab_en(fab_en)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (nres && prog_shft != 0) begin
      pulses++;
      chk("onehot", 64'($countones(prog_shft)), 1);
      if (q.size() == 0) chk("unexpected_shft", {prog_shft, prog_i}, 0);
      else begin
        e = q.pop_front();
        chk("shft_word", {prog_shft, prog_i}, e);
      end
    end
  end
  task automatic idle(input int c);
    repeat (c) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send(input logic [31:0] w);
    int t = 0;
    s_valid = 1;
    s_data = w;
    while (!s_ready && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("ready", s_ready, 1);
    @(posedge clk);
    #1;
    s_valid = 0;
  endtask
  task automatic do_reset();
    s_valid = 0;
    nres = 0;
    #1;
    chk("rst_outs", {prog_i, prog_shft, chain_loaded, cfg_done, cfg_err, fab_en, s_ready}, 0);
    idle(2);
    q.delete();
    nres = 1;
    chk("rst_ready0", s_ready, 0);
    idle(1);
    chk("rst_ready1", s_ready, 1);
  endtask
  task automatic frame(input int idx, input int n, input bit gap, input bit rnd, input bit bad);
    logic [31:0] w;
    logic [31:0] acc = 0;
    send({8'hA5, 8'h00, 8'(idx), 8'(n)});
    for (int k = 0; k < n; k++) begin
      w = rnd ? $urandom : 32'hF000_0000 >> (4 * (k % 8));
      acc ^= w;
      q.push_back({7'(1) << idx, w});
      send(w);
      if (gap) idle(1);
    end
    send(bad ? acc ^ 32'd1 : acc);
    idle(2);
    chk("q_drained", q.size(), 0);
  endtask
  initial begin
    #2;
    do_reset();
    pulses = 0;
    frame(0, 2, 0, 0, 0);
    chk("t1_pulses", pulses, 2);
    chk("t1_loaded", chain_loaded, 7'h01);
    chk("t1_trailer_word", prog_i, 32'h0F00_0000);
    do_reset();
    for (int i = 0; i < 7; i++) frame(i, 8, 0, 0, 0);
    chk("t2_loaded", chain_loaded, 7'h7F);
    chk("t2_not_done_yet", cfg_done, 0);
    send(32'hA500_FF00);
    chk("t2_done", {cfg_done, fab_en, s_ready, cfg_err}, 4'b1100);
    p0 = pulses;
    s_valid = 1;
    s_data = 32'hA500_0101;
    idle(3);
    s_valid = 0;
    chk("t2_done_ignores", {cfg_done, fab_en, s_ready, cfg_err}, 4'b1100);
    chk("t2_no_pulse", pulses, p0);
    do_reset();
    frame(0, 2, 0, 0, 1);
    chk("t3_err", {cfg_err, cfg_done, fab_en, s_ready}, 4'b1000);
    chk("t3_loaded", chain_loaded, 0);
    p0 = pulses;
    s_valid = 1;
    s_data = 32'hA500_0101;
    idle(3);
    s_valid = 0;
    chk("t3_hdr_ignored", {cfg_err, s_ready, chain_loaded}, {1'b1, 1'b0, 7'h00});
    chk("t3_no_pulse", pulses, p0);
    do_reset();
    pulses = 0;
    frame(3, 8, 1, 1, 0);
    chk("t4_pulses", pulses, 8);
    chk("t4_loaded", chain_loaded, 7'h08);
    frame(3, 8, 0, 1, 0);
    chk("t4_reload", chain_loaded, 7'h08);
    pulses = 0;
    frame(6, 255, 0, 1, 0);
    chk("n255_pulses", pulses, 255);
    chk("n255_loaded", chain_loaded, 7'h48);
    do_reset();
    send(32'h5A00_0102);
    chk("t5_sync", {cfg_err, s_ready}, 2'b10);
    do_reset();
    send(32'hA500_0702);
    chk("t5_idx7", {cfg_err, s_ready}, 2'b10);
    do_reset();
    send(32'hA500_0300);
    chk("t5_n0", {cfg_err, s_ready}, 2'b10);
    do_reset();
    for (int i = 0; i < 6; i++) frame(i, 1, 0, 1, 0);
    chk("t5_loaded3f", chain_loaded, 7'h3F);
    send(32'hA500_FF00);
    chk("t5_commit", {cfg_err, cfg_done, fab_en}, 3'b100);
    do_reset();
    send(32'hA500_0208);
    for (int k = 0; k < 3; k++) begin
      q.push_back({7'h04, 32'hF000_0000 >> (4 * k)});
      send(32'hF000_0000 >> (4 * k));
    end
    idle(1);
    chk("t6_q_before", q.size(), 0);
    nres = 0;
    #1;
    chk("t6_async", {prog_i, prog_shft, chain_loaded, cfg_done, cfg_err, fab_en, s_ready}, 0);
    idle(2);
    nres = 1;
    idle(1);
    chk("t6_ready", s_ready, 1);
    frame(2, 8, 0, 0, 0);
    chk("t6_loaded", chain_loaded, 7'h04);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end
endmodule
